// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: opcode encodings, FSM state
// encodings and the opcode legality check used when loading an opcode.
package alu_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OPC_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OPC_W-1:0] OP_AND = 6'b100100;
  localparam logic [OPC_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OPC_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OPC_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OPC_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OPC_W-1:0] OP_NOR = 6'b100111;

  typedef enum logic [1:0] {
    S_WAIT_A  = 2'b00,
    S_WAIT_B  = 2'b01,
    S_WAIT_OP = 2'b10,
    S_READY   = 2'b11
  } state_e;

  // True only for the eight opcodes the ALU implements.
  function automatic logic is_legal_opcode(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button: 2-FF synchronizer, counter-based debouncer that accepts a
// level change after DEBOUNCE_CYCLES stable cycles, and a one-cycle pulse on
// each accepted rising edge. Releases never produce a pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int NB_DEB_CNT      = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_event
);

  localparam logic [NB_DEB_CNT-1:0] CNT_LAST = NB_DEB_CNT'(DEBOUNCE_CYCLES - 1);

  logic [1:0]            sync_q;
  logic                  deb_q;
  logic                  deb_dly_q;
  logic [NB_DEB_CNT-1:0] cnt_q;
  logic                  sync_lvl;

  assign sync_lvl = sync_q[1];

  // Synchronize, debounce and delay the debounced level for edge detection.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, exactly like the flops it describes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q    <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], i_btn};
      deb_dly_q <= deb_q;
      if (sync_lvl == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_q <= sync_lvl;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + NB_DEB_CNT'(1);
      end
    end
  end

  assign o_event = deb_q & ~deb_dly_q;

endmodule

// File: rtl/alu_load_ctrl.sv
// ALU front-end controller: debounces the four buttons, then sequences the
// loading of operand A, operand B and opcode from the shared switch bank and
// issues a registered one-cycle execute strobe when the result is requested.
module alu_load_ctrl
  import alu_pkg::*;
#(
  parameter int NB_OPERANDO     = 8,
  parameter int NB_OPCODE       = 6,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int NB_DEB_CNT      = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NB_OPERANDO-1:0] i_switch,
  input  logic                   i_boton_1,
  input  logic                   i_boton_2,
  input  logic                   i_boton_3,
  input  logic                   i_boton_4,
  output logic [NB_OPERANDO-1:0] o_dato_a,
  output logic [NB_OPERANDO-1:0] o_dato_b,
  output logic [NB_OPCODE-1:0]   o_opcode,
  output logic                   o_exec,
  output logic [1:0]             o_state,
  output logic                   o_error
);

  logic [3:0] btn;
  logic [3:0] ev;

  assign btn = {i_boton_4, i_boton_3, i_boton_2, i_boton_1};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .NB_DEB_CNT      (NB_DEB_CNT)
    ) u_deb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_btn   (btn[i]),
      .o_event (ev[i])
    );
  end

  state_e                 state_q;
  logic [NB_OPERANDO-1:0] dato_a_q;
  logic [NB_OPERANDO-1:0] dato_b_q;
  logic [NB_OPCODE-1:0]   opcode_q;
  logic                   exec_q;
  logic                   error_q;
  logic                   op_legal;

  assign op_legal = is_legal_opcode(OPC_W'(i_switch[NB_OPCODE-1:0]));

  // Load sequencer: only the highest-priority event (e1 > e2 > e3 > e4) acts.
  // NOTE: reset puts every output register in a defined state, so the ALU
  // never sees undefined operands or a spurious strobe after power-up.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_WAIT_A;
      dato_a_q <= '0;
      dato_b_q <= '0;
      opcode_q <= NB_OPCODE'(OP_ADD);
      exec_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      exec_q <= 1'b0;
      if (ev[0]) begin
        dato_a_q <= i_switch;
        state_q  <= S_WAIT_B;
        error_q  <= 1'b0;
      end else if (ev[1]) begin
        if (state_q == S_WAIT_A) begin
          error_q <= 1'b1;
        end else begin
          dato_b_q <= i_switch;
          if (state_q == S_WAIT_B) state_q <= S_WAIT_OP;
        end
      end else if (ev[2]) begin
        if ((state_q == S_WAIT_OP || state_q == S_READY) && op_legal) begin
          opcode_q <= i_switch[NB_OPCODE-1:0];
          state_q  <= S_READY;
        end else begin
          error_q <= 1'b1;
        end
      end else if (ev[3]) begin
        if (state_q == S_READY) exec_q  <= 1'b1;
        else                    error_q <= 1'b1;
      end
    end
  end

  assign o_dato_a = dato_a_q;
  assign o_dato_b = dato_b_q;
  assign o_opcode = opcode_q;
  assign o_exec   = exec_q;
  assign o_state  = state_q;
  assign o_error  = error_q;

endmodule

// File: tb/tb_alu_load_ctrl.sv
// Self-checking bench for alu_load_ctrl: a behavioural model tracks the
// expected registers; every accepted execute press pushes the expected
// operands to a queue that is popped whenever o_exec is seen high.
module tb_alu_load_ctrl;

  localparam int DEB       = 2;
  localparam int LOAD_EDGE = 2 + DEB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       b1, b2, b3, b4;
  logic [7:0] o_dato_a, o_dato_b;
  logic [5:0] o_opcode;
  logic       o_exec, o_error;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  alu_load_ctrl #(
    .NB_OPERANDO     (8),
    .NB_OPCODE       (6),
    .DEBOUNCE_CYCLES (DEB),
    .NB_DEB_CNT      (8)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_switch  (sw),
    .i_boton_1 (b1),
    .i_boton_2 (b2),
    .i_boton_3 (b3),
    .i_boton_4 (b4),
    .o_dato_a  (o_dato_a),
    .o_dato_b  (o_dato_b),
    .o_opcode  (o_opcode),
    .o_exec    (o_exec),
    .o_state   (o_state),
    .o_error   (o_error)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0] m_a, m_b;
  logic [5:0] m_op;
  logic [1:0] m_st;
  logic       m_err;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
  } exec_t;

  exec_t exp_q[$];
  exec_t got_e;

  function automatic logic legal(input logic [5:0] op);
    case (op)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_op = 6'b100000; m_st = 2'b00; m_err = 1'b0;
  endtask

  task automatic model_apply(input logic [3:0] ev, input logic [7:0] s, output logic exec);
    exec = 1'b0;
    if (ev[0]) begin
      m_a = s; m_st = 2'b01; m_err = 1'b0;
    end else if (ev[1]) begin
      if (m_st == 2'b00) m_err = 1'b1;
      else begin
        m_b = s;
        if (m_st == 2'b01) m_st = 2'b10;
      end
    end else if (ev[2]) begin
      if (m_st[1] && legal(s[5:0])) begin
        m_op = s[5:0]; m_st = 2'b11;
      end else m_err = 1'b1;
    end else if (ev[3]) begin
      if (m_st == 2'b11) begin
        exec = 1'b1;
        exp_q.push_back('{a: m_a, b: m_b, op: m_op});
      end else m_err = 1'b1;
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".a"},     32'(o_dato_a), 32'(m_a));
    check({tag, ".b"},     32'(o_dato_b), 32'(m_b));
    check({tag, ".op"},    32'(o_opcode), 32'(m_op));
    check({tag, ".state"}, 32'(o_state),  32'(m_st));
    check({tag, ".err"},   32'(o_error),  32'(m_err));
  endtask

  task automatic set_btns(input logic [3:0] v);
    {b4, b3, b2, b1} = v;
  endtask

  // Hold the given buttons for 'hold' sampling edges; verify nothing moves
  // one edge early and the load/strobe lands exactly on LOAD_EDGE.
  task automatic press(input logic [3:0] btns, input int hold, input logic [7:0] s, input string tag);
    logic [3:0] ev;
    logic       exp_exec;
    ev = (hold >= DEB + 1) ? btns : 4'b0000;
    @(negedge clk);
    sw = s;
    set_btns(btns);
    for (int k = 0; k <= LOAD_EDGE + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == hold - 1) set_btns(4'b0000);
      if (k == LOAD_EDGE - 1) begin
        check_outs({tag, ".pre"});
        check({tag, ".pre_exec"}, 32'(o_exec), 32'(0));
      end
      if (k == LOAD_EDGE) begin
        model_apply(ev, s, exp_exec);
        check_outs(tag);
        check({tag, ".exec"}, 32'(o_exec), 32'(exp_exec));
      end
      if (k == LOAD_EDGE + 1) check({tag, ".exec_off"}, 32'(o_exec), 32'(0));
    end
    repeat (hold + 3) @(posedge clk);
  endtask

  // Every strobe must match one queued expectation.
  always @(negedge clk) begin
    if (o_exec === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("exec_unexpected", 32'(1), 32'(0));
      end else begin
        got_e = exp_q.pop_front();
        check("exec_a",  32'(o_dato_a), 32'(got_e.a));
        check("exec_b",  32'(o_dato_b), 32'(got_e.b));
        check("exec_op", 32'(o_opcode), 32'(got_e.op));
      end
    end
  end

  initial begin
    rst = 1'b1;
    sw  = 8'h00;
    set_btns(4'b0000);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset");
    check("reset.exec", 32'(o_exec), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Main load/execute sequence
    press(4'b0001, 3, 8'hC0, "ld_a");
    press(4'b0010, 3, 8'h01, "ld_b");
    press(4'b0100, 3, 8'h20, "op_add");
    press(4'b1000, 3, 8'h5A, "exec1");
    press(4'b0100, 3, 8'h22, "op_sub");
    press(4'b1000, 3, 8'h00, "exec2");
    press(4'b1000, 4, 8'h00, "exec2_again");

    // Illegal opcode in WAIT_OP, recovery, e2 in READY
    press(4'b0001, 4, 8'h05, "ld_a2");
    press(4'b0010, 3, 8'h07, "ld_b2");
    press(4'b0100, 3, 8'h3F, "op_bad");
    press(4'b0100, 3, 8'h24, "op_and");
    press(4'b0010, 3, 8'h0B, "ld_b_ready");
    press(4'b1000, 3, 8'h00, "exec3");

    // Simultaneous b1+b3 from READY, then a glitch
    press(4'b0101, 3, 8'h11, "b1_b3");
    press(4'b0001, 1, 8'hAA, "glitch");
    press(4'b1000, 3, 8'h00, "exec_in_wb");
    press(4'b0010, 3, 8'h09, "ld_b3");
    press(4'b0100, 3, 8'h03, "op_sra");
    press(4'b1000, 3, 8'h00, "exec4");

    // Reset while an execute press is still being debounced
    @(negedge clk);
    set_btns(4'b1000);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outs("async_rst");
    check("async_rst.exec", 32'(o_exec), 32'(0));
    @(negedge clk);
    set_btns(4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_outs("post_rst");

    // Sequence violations from reset, cleared by e1
    press(4'b1000, 3, 8'h00, "b4_idle");
    press(4'b0010, 3, 8'h33, "b2_idle");
    press(4'b0001, 3, 8'h7E, "b1_clear");

    repeat (5) @(posedge clk);
    check("exec_missing", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
